// File: rtl/int_divider_core.sv
// Sequential restoring integer divider: one quotient bit per clock, divide-by-zero flag, state exposed on cs.
// Define SIGNED_DIV_EN to add the sgn port and two's-complement (truncating) division.
module int_divider_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       cs
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             accept, div_zero, qbit;
  logic [WIDTH-1:0] x_q, y_q, r_q;
  logic [WIDTH-1:0] x_nxt, r_nxt;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, q_fin, r_fin;
  logic [WIDTH:0]   t, diff;
  logic [CNT_W-1:0] count_q;

  assign accept   = go && (state != CALC);
  assign div_zero = (divisor == '0);
  assign cs       = state;

  // R < Y always holds, so T - Y stays below 2^WIDTH when T >= Y; bit WIDTH is the borrow
  assign t     = {r_q, x_q[WIDTH-1]};
  assign diff  = t - {1'b0, y_q};
  assign qbit  = ~diff[WIDTH];
  assign r_nxt = qbit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  assign x_nxt = {x_q[WIDTH-2:0], qbit};

`ifdef SIGNED_DIV_EN
  logic dvd_neg, dvs_neg, q_neg_q, r_neg_q;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign dvd_neg = sgn && ($signed(dividend) < 0);
  assign dvs_neg = sgn && ($signed(divisor) < 0);
  assign dvd_mag = neg_if(dividend, dvd_neg);
  assign dvs_mag = neg_if(divisor, dvs_neg);
  assign q_fin   = neg_if(x_nxt, q_neg_q);
  assign r_fin   = neg_if(r_nxt, r_neg_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (accept && !div_zero) begin
      q_neg_q <= dvd_neg ^ dvs_neg;
      r_neg_q <= dvd_neg;
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fin   = x_nxt;
  assign r_fin   = r_nxt;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (go) state_next = div_zero ? FIN : CALC;
      CALC: if (count_q == '0) state_next = FIN;
      FIN: begin
        if (go) state_next = div_zero ? FIN : CALC;
        else    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == CALC);
      done  <= (state_next == FIN);
    end
  end

  // Operand latch, iteration and result capture on the final CALC edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      r_q       <= '0;
      count_q   <= '0;
      error     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      if (div_zero) begin
        error     <= 1'b1;
        quotient  <= '1;
        remainder <= dividend;
      end else begin
        x_q     <= dvd_mag;
        y_q     <= dvs_mag;
        r_q     <= '0;
        count_q <= CNT_W'(WIDTH - 1);
        error   <= 1'b0;
      end
    end else if (state == CALC) begin
      x_q <= x_nxt;
      r_q <= r_nxt;
      if (count_q == '0) begin
        quotient  <= q_fin;
        remainder <= r_fin;
      end else begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule
